// File: rtl/m68k_bus_master_if.sv
// Command/response handshake plus CPU-side 68000 bus signals for m68k_bus_master.
interface m68k_bus_master_if;
    logic        clk_en_half;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_uds;
    logic        cmd_lds;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        n_dtack;
    logic [15:0] m68k_data_in;
    logic [2:0]  fc;
    logic        n_as;
    logic        m68k_rw;
    logic        n_uds;
    logic        n_lds;
    logic [22:0] m68k_addr;
    logic [15:0] m68k_data_out;
    logic        m68k_data_oe;

    modport master (
        input  clk_en_half, cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_uds, cmd_lds,
        input  n_dtack, m68k_data_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output fc, n_as, m68k_rw, n_uds, n_lds, m68k_addr, m68k_data_out, m68k_data_oe
    );

    modport slave (
        output clk_en_half, cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_uds, cmd_lds,
        output n_dtack, m68k_data_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  fc, n_as, m68k_rw, n_uds, n_lds, m68k_addr, m68k_data_out, m68k_data_oe
    );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style bus-cycle initiator: turns a command handshake into S0-S7 read/write cycles.
// Optional DTACK timeout abort is built when M68K_BUS_MASTER_TIMEOUT_EN is defined.
module m68k_bus_master #(
    parameter logic [2:0]  FC_CODE = 3'b101,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               i_clk,
    input logic               i_rst,
    m68k_bus_master_if.master bus
);
    localparam logic [2:0] FcIdle = 3'b111;

    typedef enum logic [3:0] {
        StIdle, StS0, StS1, StS2, StS3, StS4, StW1, StW2, StS5, StS6, StS7
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [22:0] r_cmd_addr, w_cmd_addr_nxt;
    logic [15:0] r_cmd_data, w_cmd_data_nxt;
    logic        r_cmd_uds, w_cmd_uds_nxt;
    logic        r_cmd_lds, w_cmd_lds_nxt;
    logic [2:0]  r_fc, w_fc_nxt;
    logic        r_n_as, w_n_as_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_n_uds, w_n_uds_nxt;
    logic        r_n_lds, w_n_lds_nxt;
    logic [22:0] r_addr, w_addr_nxt;
    logic [15:0] r_dout, w_dout_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [15:0] r_rsp_data, w_rsp_data_nxt;
    logic        w_to_s7;
    logic        w_timeout_hit;

`ifdef M68K_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CntW-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;
    assign w_timeout_hit = (r_wait_cnt == CntW'(TIMEOUT));
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_data_nxt  = r_cmd_data;
        w_cmd_uds_nxt   = r_cmd_uds;
        w_cmd_lds_nxt   = r_cmd_lds;
        w_fc_nxt        = r_fc;
        w_n_as_nxt      = r_n_as;
        w_rw_nxt        = r_rw;
        w_n_uds_nxt     = r_n_uds;
        w_n_lds_nxt     = r_n_lds;
        w_addr_nxt      = r_addr;
        w_dout_nxt      = r_dout;
        w_oe_nxt        = r_oe;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_to_s7         = 1'b0;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
        w_wait_cnt_nxt  = r_wait_cnt;
        w_rsp_err_nxt   = r_rsp_err;
`endif
        unique case (r_state)
            // Accept does not wait for a half-cycle enable.
            StIdle: begin
                if (bus.cmd_valid) begin
                    w_state_nxt    = StS0;
                    w_cmd_addr_nxt = bus.cmd_addr;
                    w_cmd_data_nxt = bus.cmd_data;
                    w_cmd_uds_nxt  = bus.cmd_uds;
                    w_cmd_lds_nxt  = bus.cmd_lds;
                    w_fc_nxt       = FC_CODE;
                    w_rw_nxt       = bus.cmd_rw;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
                    w_wait_cnt_nxt = '0;
                    w_rsp_err_nxt  = 1'b0;
`endif
                end
            end
            StS0: if (bus.clk_en_half) begin
                w_state_nxt = StS1;
                w_addr_nxt  = r_cmd_addr;
            end
            StS1: if (bus.clk_en_half) begin
                w_state_nxt = StS2;
                w_n_as_nxt  = 1'b0;
                if (r_rw) begin
                    w_n_uds_nxt = ~r_cmd_uds;
                    w_n_lds_nxt = ~r_cmd_lds;
                end
            end
            StS2: if (bus.clk_en_half) begin
                w_state_nxt = StS3;
                if (!r_rw) begin
                    w_oe_nxt    = 1'b1;
                    w_dout_nxt  = r_cmd_data;
                    w_n_uds_nxt = ~r_cmd_uds;
                    w_n_lds_nxt = ~r_cmd_lds;
                end
            end
            StS3: if (bus.clk_en_half) w_state_nxt = StS4;
            // W2 re-samples DTACK so each extra wait pair costs exactly two half-cycles.
            StS4, StW2: if (bus.clk_en_half) begin
                if (!bus.n_dtack) begin
                    w_state_nxt = StS5;
                end else if (w_timeout_hit) begin
                    w_to_s7 = 1'b1;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
                    w_rsp_err_nxt = 1'b1;
`endif
                end else begin
                    w_state_nxt = StW1;
`ifdef M68K_BUS_MASTER_TIMEOUT_EN
                    w_wait_cnt_nxt = r_wait_cnt + CntW'(1);
`endif
                end
            end
            StW1: if (bus.clk_en_half) w_state_nxt = StW2;
            StS5: if (bus.clk_en_half) w_state_nxt = StS6;
            StS6: if (bus.clk_en_half) begin
                w_to_s7 = 1'b1;
                if (r_rw) w_rsp_data_nxt = bus.m68k_data_in;
            end
            StS7: if (bus.clk_en_half) begin
                w_state_nxt     = StIdle;
                w_rsp_valid_nxt = 1'b1;
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_to_s7) begin
            w_state_nxt = StS7;
            w_n_as_nxt  = 1'b1;
            w_n_uds_nxt = 1'b1;
            w_n_lds_nxt = 1'b1;
            w_oe_nxt    = 1'b0;
            w_fc_nxt    = FcIdle;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_cmd_uds   <= 1'b0;
            r_cmd_lds   <= 1'b0;
            r_fc        <= FcIdle;
            r_n_as      <= 1'b1;
            r_rw        <= 1'b1;
            r_n_uds     <= 1'b1;
            r_n_lds     <= 1'b1;
            r_addr      <= '0;
            r_dout      <= '0;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
            r_cmd_uds   <= w_cmd_uds_nxt;
            r_cmd_lds   <= w_cmd_lds_nxt;
            r_fc        <= w_fc_nxt;
            r_n_as      <= w_n_as_nxt;
            r_rw        <= w_rw_nxt;
            r_n_uds     <= w_n_uds_nxt;
            r_n_lds     <= w_n_lds_nxt;
            r_addr      <= w_addr_nxt;
            r_dout      <= w_dout_nxt;
            r_oe        <= w_oe_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

`ifdef M68K_BUS_MASTER_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
        end
    end
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready     = (r_state == StIdle);
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.fc            = r_fc;
    assign bus.n_as          = r_n_as;
    assign bus.m68k_rw       = r_rw;
    assign bus.n_uds         = r_n_uds;
    assign bus.n_lds         = r_n_lds;
    assign bus.m68k_addr     = r_addr;
    assign bus.m68k_data_out = r_dout;
    assign bus.m68k_data_oe  = r_oe;
endmodule

// File: doc/m68k_bus_master.md
Name: m68k_bus_master

Overview:
- Synthesizable 68000-style bus-cycle initiator.
- Drives the CPU-side bus of the LSPC: FC[2:0], nAS, M68K_RW, nUDS, nLDS, M68K_ADDR[23:1], M68K_DATA.
- Turns a simple command handshake into correctly sequenced S0–S7 read/write cycles, honouring nDTACK wait states.
- Used to preload VRAM and LSPC registers (0x3C0000–0x3C000E) for savestate restore and headless video simulation, with no CPU core.

Parameters:
- FC_CODE, 3'b101, function code driven during every cycle (supervisor data).
- TIMEOUT, 64, max wait-state pairs before abort; only used with the optional feature.

Ports:
- CLK  in  1  system clock (48 MHz).
- RESET  in  1  asynchronous, active-high reset.
- CLK_EN_HALF  in  1  one-CLK pulse per 68K half-cycle (24 MHz rate); every state step happens only on CLK with CLK_EN_HALF=1.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  master idle; command accepted when VALID&READY.
- CMD_RW  in  1  1=read, 0=write.
- CMD_ADDR  in  23  word address [23:1].
- CMD_DATA  in  16  write data.
- CMD_UDS  in  1  upper byte enable.
- CMD_LDS  in  1  lower byte enable.
- RSP_VALID  out  1  one-CLK pulse when a cycle completes.
- RSP_DATA  out  16  read data; held until the next read completes.
- RSP_ERR  out  1  qualified by RSP_VALID; 1 = timeout abort.
- nDTACK  in  1  active-low data acknowledge.
- M68K_DATA_IN  in  16  bus read data.
- FC  out  3  function code.
- nAS  out  1  address strobe.
- M68K_RW  out  1  read/write.
- nUDS  out  1  upper data strobe.
- nLDS  out  1  lower data strobe.
- M68K_ADDR  out  23  address.
- M68K_DATA_OUT  out  16  write data.
- M68K_DATA_OE  out  1  data bus drive enable.

Behaviour:
- Reset values:
  - State IDLE; CMD_READY=1.
  - nAS=nUDS=nLDS=1; M68K_RW=1; FC=3'b111.
  - M68K_ADDR=0; M68K_DATA_OUT=0; M68K_DATA_OE=0.
  - RSP_VALID=0; RSP_DATA=0; RSP_ERR=0.
- Reset mid-cycle: all strobes negate immediately (async); the command is lost and no RSP_VALID is issued.
- Command latch: on the CLK where CMD_VALID&CMD_READY, the command is latched, CMD_READY drops the same edge, and the state goes to S0. The latch is independent of CLK_EN_HALF.
- States (one CLK_EN_HALF each unless noted):
  - S0: drive FC=FC_CODE; M68K_RW=CMD_RW; strobes negated.
  - S1: M68K_ADDR valid.
  - S2: nAS=0. For a read, nUDS/nLDS = ~CMD_UDS/~CMD_LDS.
  - S3: For a write, M68K_DATA_OE=1 with data driven, then the data strobes assert.
  - S4: sample nDTACK.
    - nDTACK=0 → S5.
    - nDTACK=1 → insert a wait pair (W1, W2) and return to S4.
  - S5: no change.
  - S6: for a read, RSP_DATA <= M68K_DATA_IN.
  - S7: nAS, nUDS, nLDS negate; M68K_DATA_OE=0; FC=3'b111; RSP_VALID pulses on the S7 edge.
- After S7: return to IDLE with CMD_READY=1. The next command can be accepted on the following CLK, so minimum spacing is 8 half-cycles (4 68K clocks) per zero-wait cycle.
- Write data and address stay stable from S1/S3 through S7.
- Wait states:
  - Each extra pair adds 2 half-cycles.
  - nDTACK is sampled only in S4 and each W2; glitches between samples are ignored.
- Byte enables:
  - CMD_UDS=CMD_LDS=0 is a legal no-strobe cycle: nAS toggles, the data strobes stay negated, and DTACK is still awaited.
- CMD_VALID held with READY=0: no effect. The command must stay stable only on the accept edge.
- M68K_RW changes only in S0 and IDLE; it is never changed while nAS=0.

Optional Feature:
- Macro: M68K_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A wait-pair counter (width = clog2(TIMEOUT+1)) clears in S0 and increments per wait pair.
  - When it reaches TIMEOUT while nDTACK=1, the cycle proceeds directly to S7: strobes negate, RSP_VALID=1 with RSP_ERR=1, and RSP_DATA is unchanged.
- Undefined: the master waits indefinitely; RSP_ERR is tied 0.

Test Plan:
- Write, zero wait: CMD write ADDR=0x1E0000 (0x3C0000>>1), DATA=0x8000, UDS=LDS=1; nDTACK tied 0 → nAS low exactly 5 half-cycles (S2–S6), M68K_DATA_OUT=0x8000 with OE=1 S3–S6, RSP_VALID 8 half-cycles after accept, RSP_ERR=0.
- Read with waits: nDTACK released 3 pairs late, M68K_DATA_IN=0x1234 → nAS low 11 half-cycles, RSP_DATA=0x1234, OE never asserted, M68K_RW=1 throughout.
- Byte write: UDS=0, LDS=1 → nUDS stays 1, nLDS=0 S3–S6 only.
- Back-to-back: two commands with CMD_VALID held → second S0 starts one CLK after first RSP_VALID; nAS negated ≥1 half-cycle between cycles.
- Timeout (macro on, TIMEOUT=4): nDTACK stuck 1 → strobes negate after 4 wait pairs, RSP_VALID=1, RSP_ERR=1, CMD_READY returns to 1; with macro off, nAS stays 0 after 100 half-cycles.
- Reset in S4: assert RESET → nAS, nUDS, nLDS=1 and OE=0 without waiting for CLK; after release CMD_READY=1 and no RSP_VALID has been issued.
